bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter producing the packed digit vector consumed by the on-screen `numbers` renderer. Takes a W-bit unsigned value on a start strobe, runs a shift-and-add-3 (double-dabble) loop of one bit per clock, and presents L decimal digits, most significant first, in the renderer's `data` layout. Sits between game logic (score, lives, timer counters) and the video overlay; output is held stable between conversions so the renderer never sees intermediate values.

## Interface
- `W`, default 8: width of binary input, 1..16.
- `L`, default 2: number of displayed digits; must equal the renderer's `L`.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin`  in  W  unsigned value; captured on accepted `start`.
- `busy`  out  1  high while conversion in progress.
- `done`  out  1  one-cycle pulse when `data` is updated.
- `data`  out  [L-1:0][3:0]  BCD digits; `data[0]` = most significant (leftmost on screen), `data[L-1]` = units.
- `overflow`  out  1  value ≥ 10^L; updated with `done`, held until next completion.

## Operation
- Internal scratch: ND = (W+2)/3 BCD nibbles plus W-bit shift register, bit counter of width ≥ clog2(W+1).
- States: IDLE, SHIFT.
- IDLE: `start`=1 → latch `bin` into shift register, clear scratch, counter = W, go SHIFT. `start`=0 → stay.
- SHIFT, each cycle: every scratch nibble ≥ 5 gets +3 (4-bit, no carry between nibbles), then {scratch, shift reg} shifts left one bit; counter decrements. When counter reaches 1 on this cycle (last shift), go IDLE and, in the same edge, load outputs from the post-shift scratch.
- Output load: `data[i]` = scratch digit (L-1-i); digits beyond ND read as 0. `overflow` = OR of all scratch digits at index ≥ L (0 if L ≥ ND). `done` pulses.
- `start` in SHIFT is ignored (not queued). `bin` changes after capture have no effect.
- `data` and `overflow` change only on a completion edge or reset.
- W=1 edge case: single SHIFT cycle, identical rules.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `overflow`=0, `data` all 4'h0, scratch cleared. Reset mid-conversion aborts; no `done`.
- `start` sampled at edge k in IDLE → `busy`=1 after edge k.
- Shifts occur on edges k+1 … k+W; after edge k+W: `busy`=0, `done`=1, `data`/`overflow` valid. Latency W clocks start-to-done.
- `done` high exactly one cycle; deasserts after edge k+W+1 unless a new conversion completes there (impossible for W ≥ 1).
- Back-to-back: `start` high during the `done` cycle is accepted (FSM already IDLE); throughput one result per W+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `BIN2BCD_SAT_EN` defined: on overflow, `data` loads all digits 4'h9 (display saturates, e.g. "99"); `overflow`=1.
- Not defined: on overflow, `data` loads the low L digits (value mod 10^L); `overflow`=1.
- Non-overflow results identical in both builds.

## Test plan
- W=8, L=2, reset released, `bin`=42, `start` 1 cycle → `busy` 8 cycles, `done` pulse 8 clocks after start edge, `data[0]`=4, `data[1]`=2, `overflow`=0.
- `bin`=255 → `overflow`=1; without macro `data`={5,5}; with `BIN2BCD_SAT_EN` `data`={9,9}. Then `bin`=99 → {9,9}, `overflow`=0 in both.
- `bin`=0 and `bin`=9 → {0,0} and {0,9}; `bin`=10 → {1,0}.
- `start`=1 with `bin`=7 at cycle 3 of a conversion of 63 → ignored; result {6,3}, single `done`; `start` held high through `done` cycle → second conversion begins immediately, `done` again W+1 cycles later.
- Assert `reset` at cycle 4 of converting 200 (previous result {4,2}) → outputs zero immediately, no `done`; next conversion of 15 → {1,5}.
- Exhaustive sweep W=8, L=3: all 0..255 → digits match decimal value, `overflow` never set.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per clock, into L renderer digits.
// Define BIN2BCD_SAT_EN to saturate the displayed digits at all nines on overflow.
module bin2bcd_seq #(
    parameter int W = 8,
    parameter int L = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      bin,
    output logic              busy,
    output logic              done,
    output logic [L-1:0][3:0] data,
    output logic              overflow
);
    localparam int ND = (W + 2) / 3;
    localparam int NP = ND > L ? ND : L;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, nstate;
    logic [ND*4-1:0]     bcd, adj, nbcd;
    logic [W-1:0]        sr, nsr;
    logic [CW-1:0]       cnt;
    logic [NP*4-1:0]     pad;
    logic [L-1:0][3:0]   res;
    logic                ov, last;

    assign last = cnt == CW'(1);
    assign busy = state == SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        {nbcd, nsr} = {adj, sr} << 1;
    end

    // Digits above ND are implicitly zero via the padded copy.
    always_comb begin
        pad = '0;
        pad[ND*4-1:0] = nbcd;
        ov = 1'b0;
        for (int i = L; i < ND; i++)
            ov = ov | (pad[4*i +: 4] != 4'd0);
        res = '0;
        for (int i = 0; i < L; i++)
`ifdef BIN2BCD_SAT_EN
            res[i] = ov ? 4'h9 : pad[4*(L-1-i) +: 4];
`else
            res[i] = pad[4*(L-1-i) +: 4];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd      <= '0;
            sr       <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                sr  <= bin;
                bcd <= '0;
                cnt <= CW'(W);
            end else if (state == SHIFT) begin
                bcd <= nbcd;
                sr  <= nsr;
                cnt <= cnt - CW'(1);
                if (last) begin
                    done     <= 1'b1;
                    data     <= res;
                    overflow <= ov;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;
    typedef logic [1:0][3:0] d2_t;
    typedef logic [2:0][3:0] d3_t;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] bin = '0;
    logic       busy2, done2, ov2, busy3, done3, ov3;
    d2_t        data2, last2;
    d3_t        data3, last3;
    int         tests = 0, fails = 0;

    bin2bcd_seq #(.W(8), .L(2)) dut2 (.clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy2), .done(done2), .data(data2), .overflow(ov2));
    bin2bcd_seq #(.W(8), .L(3)) dut3 (.clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy3), .done(done3), .data(data3), .overflow(ov3));

    always #5 clk = ~clk;

    function automatic d2_t m2(int v);
        int u = v % 100;
`ifdef BIN2BCD_SAT_EN
        if (v >= 100) u = 99;
`endif
        m2[0] = 4'(u / 10);
        m2[1] = 4'(u % 10);
    endfunction

    function automatic d3_t m3(int v);
        m3[0] = 4'(v / 100);
        m3[1] = 4'((v / 10) % 10);
        m3[2] = 4'(v % 10);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        last2 = '0;
        last3 = '0;
        tests++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || ov2 !== 1'b0 || data2 !== 8'h00 || data3 !== 12'h000)
            begin fails++; $display("FAIL reset_state: busy=%b done=%b ov=%b data=%h/%h want zeros", busy2, done2, ov2, data2, data3); end
    endtask

    task automatic test_conversion(int v);
        bin = 8'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (busy2 !== 1'b1) begin fails++; $display("FAIL busy_after_start v=%0d: got %b want 1", v, busy2); end
        for (int j = 1; j < 8; j++) begin
            step();
            tests++;
            if (busy2 !== 1'b1 || done2 !== 1'b0 || data2 !== last2 || data3 !== last3)
                begin fails++; $display("FAIL mid_conv v=%0d cyc=%0d: busy=%b done=%b data=%h/%h want 1 0 %h/%h", v, j, busy2, done2, data2, data3, last2, last3); end
        end
        step();
        last2 = m2(v);
        last3 = m3(v);
        tests++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || done3 !== 1'b1)
            begin fails++; $display("FAIL done_pulse v=%0d: done=%b busy=%b want 1 0", v, done2, busy2); end
        tests++;
        if (data2 !== last2 || ov2 !== (v >= 100))
            begin fails++; $display("FAIL result_l2 v=%0d: data=%h ov=%b want %h %b", v, data2, ov2, last2, v >= 100); end
        tests++;
        if (data3 !== last3 || ov3 !== 1'b0)
            begin fails++; $display("FAIL result_l3 v=%0d: data=%h ov=%b want %h 0", v, data3, ov3, last3); end
        step();
        tests++;
        if (done2 !== 1'b0 || data2 !== last2)
            begin fails++; $display("FAIL done_width v=%0d: done=%b data=%h want 0 %h", v, done2, data2, last2); end
    endtask

    task automatic test_directed();
        test_conversion(42);
        test_conversion(255);
        test_conversion(99);
        test_conversion(0);
        test_conversion(9);
        test_conversion(10);
        test_conversion(100);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) test_conversion(int'($urandom_range(255)));
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bin = 8'd63;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        bin = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 4; j <= 12; j++) begin
            step();
            if (done2 === 1'b1) dones++;
            if (j == 8) begin
                tests++;
                if (data2 !== m2(63) || done2 !== 1'b1)
                    begin fails++; $display("FAIL ignore_result: data=%h done=%b want %h 1", data2, done2, m2(63)); end
            end
        end
        last2 = m2(63);
        last3 = m3(63);
        tests++;
        if (dones != 1 || busy2 !== 1'b0)
            begin fails++; $display("FAIL ignore_single_done: dones=%0d busy=%b want 1 0", dones, busy2); end
    endtask

    task automatic test_back_to_back();
        bin = 8'd63;
        start = 1'b1;
        step();
        bin = 8'd7;
        for (int j = 1; j <= 17; j++) begin
            step();
            if (j == 8) begin
                tests++;
                if (done2 !== 1'b1 || data2 !== m2(63))
                    begin fails++; $display("FAIL b2b_first: done=%b data=%h want 1 %h", done2, data2, m2(63)); end
            end else if (j == 17) begin
                tests++;
                if (done2 !== 1'b1 || data2 !== m2(7) || data3 !== m3(7))
                    begin fails++; $display("FAIL b2b_second: done=%b data=%h want 1 %h", done2, data2, m2(7)); end
            end else if (j > 8) begin
                tests++;
                if (done2 !== 1'b0 || busy2 !== 1'b1)
                    begin fails++; $display("FAIL b2b_gap cyc=%0d: done=%b busy=%b want 0 1", j, done2, busy2); end
            end
        end
        start = 1'b0;
        step();
        step();
        step();
        last2 = m2(7);
        last3 = m3(7);
    endtask

    task automatic test_reset_abort();
        test_conversion(42);
        bin = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        tests++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || ov2 !== 1'b0 || data2 !== 8'h00 || data3 !== 12'h000)
            begin fails++; $display("FAIL abort_clear: busy=%b done=%b ov=%b data=%h want 0 0 0 00", busy2, done2, ov2, data2); end
        step();
        reset = 1'b0;
        last2 = '0;
        last3 = '0;
        for (int j = 0; j < 10; j++) begin
            step();
            tests++;
            if (done2 !== 1'b0 || busy2 !== 1'b0 || data2 !== 8'h00)
                begin fails++; $display("FAIL abort_quiet cyc=%0d: done=%b busy=%b data=%h want 0 0 00", j, done2, busy2, data2); end
        end
        test_conversion(15);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) test_conversion(v);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
